// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: operand select, load-use bubble insertion.
// Define FORWARD_EN to add EX/MEM and MEM/WB operand forwarding.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [4:0]        id_shamt,
   input  logic [1:0]        id_func,
   input  logic              id_alusrc,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              id_memwrite,
   input  logic              id_memtoreg,
   input  logic              exmem_regwrite,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic [DATA_W-1:0] exmem_result,
   input  logic              memwb_regwrite,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic [DATA_W-1:0] memwb_result,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_src1,
   output logic [DATA_W-1:0] ex_src2,
   output logic [1:0]        ex_func,
   output logic [4:0]        ex_shift,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic              ex_memwrite,
   output logic              ex_memtoreg,
   output logic              load_use_hazard
);

   localparam logic [1:0] FUNC_ADD = 2'b01;

   logic              valid_q,    valid_d;
   logic [DATA_W-1:0] rs_data_q,  rs_data_d;
   logic [DATA_W-1:0] rt_data_q,  rt_data_d;
   logic [DATA_W-1:0] imm_q,      imm_d;
   logic [REG_AW-1:0] rd_q,       rd_d;
   logic [4:0]        shamt_q,    shamt_d;
   logic [1:0]        func_q,     func_d;
   logic              alusrc_q,   alusrc_d;
   logic              regwrite_q, regwrite_d;
   logic              memread_q,  memread_d;
   logic              memwrite_q, memwrite_d;
   logic              memtoreg_q, memtoreg_d;
`ifdef FORWARD_EN
   logic [REG_AW-1:0] rs_q,       rs_d;
   logic [REG_AW-1:0] rt_q,       rt_d;
`endif

   logic              bubble;
   logic              load;
   logic [DATA_W-1:0] fwd_rs;
   logic [DATA_W-1:0] fwd_rt;

   // Flush wins over everything; the hazard output is masked by flush so a
   // squashed consumer never holds the front end.
   assign load_use_hazard = valid_q & memread_q & (rd_q != '0) &
                            ((rd_q == id_rs) | (rd_q == id_rt)) &
                            id_valid & ~flush;

   assign bubble = flush | (~stall & (load_use_hazard | ~id_valid));
   assign load   = ~flush & ~stall & ~load_use_hazard & id_valid;

   always_comb begin
      valid_d    = valid_q;
      rs_data_d  = rs_data_q;
      rt_data_d  = rt_data_q;
      imm_d      = imm_q;
      rd_d       = rd_q;
      shamt_d    = shamt_q;
      func_d     = func_q;
      alusrc_d   = alusrc_q;
      regwrite_d = regwrite_q;
      memread_d  = memread_q;
      memwrite_d = memwrite_q;
      memtoreg_d = memtoreg_q;
`ifdef FORWARD_EN
      rs_d       = rs_q;
      rt_d       = rt_q;
`endif
      if (bubble) begin
         valid_d    = 1'b0;
         rs_data_d  = '0;
         rt_data_d  = '0;
         imm_d      = '0;
         rd_d       = '0;
         shamt_d    = '0;
         func_d     = FUNC_ADD;
         alusrc_d   = 1'b0;
         regwrite_d = 1'b0;
         memread_d  = 1'b0;
         memwrite_d = 1'b0;
         memtoreg_d = 1'b0;
`ifdef FORWARD_EN
         rs_d       = '0;
         rt_d       = '0;
`endif
      end else if (load) begin
         valid_d    = 1'b1;
         rs_data_d  = id_rs_data;
         rt_data_d  = id_rt_data;
         imm_d      = id_imm;
         rd_d       = id_rd;
         shamt_d    = id_shamt;
         func_d     = id_func;
         alusrc_d   = id_alusrc;
         regwrite_d = id_regwrite;
         memread_d  = id_memread;
         memwrite_d = id_memwrite;
         memtoreg_d = id_memtoreg;
`ifdef FORWARD_EN
         rs_d       = id_rs;
         rt_d       = id_rt;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         rs_data_q  <= '0;
         rt_data_q  <= '0;
         imm_q      <= '0;
         rd_q       <= '0;
         shamt_q    <= '0;
         func_q     <= FUNC_ADD;
         alusrc_q   <= 1'b0;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
`ifdef FORWARD_EN
         rs_q       <= '0;
         rt_q       <= '0;
`endif
      end else begin
         valid_q    <= valid_d;
         rs_data_q  <= rs_data_d;
         rt_data_q  <= rt_data_d;
         imm_q      <= imm_d;
         rd_q       <= rd_d;
         shamt_q    <= shamt_d;
         func_q     <= func_d;
         alusrc_q   <= alusrc_d;
         regwrite_q <= regwrite_d;
         memread_q  <= memread_d;
         memwrite_q <= memwrite_d;
         memtoreg_q <= memtoreg_d;
`ifdef FORWARD_EN
         rs_q       <= rs_d;
         rt_q       <= rt_d;
`endif
      end
   end

`ifdef FORWARD_EN
   // EX/MEM is the younger producer, so it shadows MEM/WB; r0 is hardwired.
   always_comb begin
      fwd_rs = rs_data_q;
      if (exmem_regwrite && (exmem_rd == rs_q) && (rs_q != '0))
         fwd_rs = exmem_result;
      else if (memwb_regwrite && (memwb_rd == rs_q) && (rs_q != '0))
         fwd_rs = memwb_result;
   end

   always_comb begin
      fwd_rt = rt_data_q;
      if (exmem_regwrite && (exmem_rd == rt_q) && (rt_q != '0))
         fwd_rt = exmem_result;
      else if (memwb_regwrite && (memwb_rd == rt_q) && (rt_q != '0))
         fwd_rt = memwb_result;
   end
`else
   logic unused_fwd_ports;
   assign unused_fwd_ports = ^{exmem_regwrite, exmem_rd, exmem_result,
                               memwb_regwrite, memwb_rd, memwb_result};
   assign fwd_rs = rs_data_q;
   assign fwd_rt = rt_data_q;
`endif

   assign ex_valid      = valid_q;
   assign ex_src1       = fwd_rs;
   assign ex_src2       = alusrc_q ? imm_q : fwd_rt;
   assign ex_store_data = fwd_rt;
   assign ex_func       = func_q;
   assign ex_shift      = shamt_q;
   assign ex_rd         = rd_q;
   assign ex_regwrite   = regwrite_q;
   assign ex_memread    = memread_q;
   assign ex_memwrite   = memwrite_q;
   assign ex_memtoreg   = memtoreg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; forwarding expectations follow FORWARD_EN.
module tb_id_ex_stage;

`ifdef FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct packed {
      logic        valid;
      logic [31:0] src1;
      logic [31:0] src2;
      logic [1:0]  func;
      logic [4:0]  shift;
      logic [31:0] store;
      logic [4:0]  rd;
      logic        regwrite;
      logic        memread;
      logic        memwrite;
      logic        memtoreg;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, stall, flush, id_valid;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
   logic [1:0]  id_func;
   logic        id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg;
   logic        exmem_regwrite, memwb_regwrite;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_result;
   logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
   logic [31:0] ex_src1, ex_src2, ex_store_data;
   logic [1:0]  ex_func;
   logic [4:0]  ex_shift, ex_rd;
   logic        load_use_hazard;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   exp_t last_exp;
   exp_t got, e;

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
      .id_func(id_func), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .ex_valid(ex_valid), .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_func(ex_func),
      .ex_shift(ex_shift), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_memtoreg(ex_memtoreg), .load_use_hazard(load_use_hazard)
   );

   function automatic exp_t bubble_exp();
      exp_t b;
      b = '0;
      b.func = 2'b01;
      return b;
   endfunction

   function automatic exp_t dut_out();
      exp_t o;
      o.valid = ex_valid;       o.src1 = ex_src1;         o.src2 = ex_src2;
      o.func = ex_func;         o.shift = ex_shift;       o.store = ex_store_data;
      o.rd = ex_rd;             o.regwrite = ex_regwrite; o.memread = ex_memread;
      o.memwrite = ex_memwrite; o.memtoreg = ex_memtoreg;
      return o;
   endfunction

   function automatic logic hz_model();
      return last_exp.valid & last_exp.memread & (last_exp.rd != 5'd0) &
             ((last_exp.rd == id_rs) | (last_exp.rd == id_rt)) & id_valid & ~flush;
   endfunction

   function automatic exp_t predict();
      exp_t p;
      if (rst || flush) p = bubble_exp();
      else if (stall) p = last_exp;
      else if (hz_model() || !id_valid) p = bubble_exp();
      else begin
         p.valid = 1'b1;       p.src1 = id_rs_data;
         p.src2 = id_alusrc ? id_imm : id_rt_data;
         p.func = id_func;     p.shift = id_shamt;       p.store = id_rt_data;
         p.rd = id_rd;         p.regwrite = id_regwrite; p.memread = id_memread;
         p.memwrite = id_memwrite; p.memtoreg = id_memtoreg;
      end
      return p;
   endfunction

   // Called at negedge: predict, push, clock one edge, return to negedge.
   task automatic advance();
      exp_t p;
      p = predict();
      sb.push_back(p);
      last_exp = p;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_idle();
      stall = 0; flush = 0; id_valid = 0;
      id_rs_data = 0; id_rt_data = 0; id_imm = 0;
      id_rs = 0; id_rt = 0; id_rd = 0; id_shamt = 0; id_func = 2'b01;
      id_alusrc = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
      exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
      memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
   endtask

   task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                            input logic [4:0] sh, input logic [1:0] fn, input logic asrc,
                            input logic rw, input logic mr, input logic mw, input logic mt);
      id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
      id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_shamt = sh; id_func = fn;
      id_alusrc = asrc; id_regwrite = rw; id_memread = mr; id_memwrite = mw; id_memtoreg = mt;
   endtask

   task automatic test_reset();
      set_idle();
      rst = 1;
      @(negedge clk); @(negedge clk);
      n_checks++;
      if (dut_out() !== bubble_exp()) begin
         n_fail++; $display("FAIL reset_state: got %h expected %h", dut_out(), bubble_exp());
      end
      n_checks++;
      if (load_use_hazard !== 1'b0) begin
         n_fail++; $display("FAIL reset_hazard: got %b expected 0", load_use_hazard);
      end
      rst = 0;
      last_exp = bubble_exp();
      sb.delete();
   endtask

   task automatic test_basic();
      logic [31:0] rsd [3] = '{32'd5, 32'hDEADBEEF, 32'd0};
      logic [31:0] rtd [3] = '{32'd3, 32'h1234, 32'hFFFFFFFF};
      logic [1:0]  fn  [3] = '{2'b10, 2'b00, 2'b11};
      logic [4:0]  sh  [3] = '{5'd0, 5'd31, 5'd9};
      for (int i = 0; i < 3; i++) begin
         set_instr(5'd1, 5'd2, 5'(3 + i * 14), rsd[i], rtd[i], 32'h0, sh[i], fn[i], 1'b0,
                   1'b1, 1'b0, i == 2, 1'b0);
         advance();
         got = dut_out(); e = sb.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++; $display("FAIL basic_load[%0d]: got %h expected %h", i, got, e);
         end
      end
   endtask

   task automatic test_imm();
      set_instr(5'd3, 5'd4, 5'd5, 32'd10, 32'd7, 32'hFFFFFFFC, 5'd0, 2'b01, 1'b1,
                1'b1, 1'b0, 1'b0, 1'b0);
      advance();
      got = dut_out(); e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
         n_fail++; $display("FAIL imm_load: got %h expected %h", got, e);
      end
      n_checks++;
      if (ex_src2 !== 32'hFFFFFFFC || ex_store_data !== 32'd7) begin
         n_fail++; $display("FAIL imm_select: src2 %h store %h expected fffffffc 7", ex_src2, ex_store_data);
      end
      set_instr(5'd3, 5'd4, 5'd5, 32'd10, 32'd7, 32'h1, 5'd0, 2'b01, 1'b1,
                1'b1, 1'b0, 1'b0, 1'b0);
      id_valid = 0;
      advance();
      got = dut_out(); e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
         n_fail++; $display("FAIL invalid_bubble: got %h expected %h", got, e);
      end
   endtask

   task automatic test_load_use();
      logic [4:0] lw_rd [3] = '{5'd4, 5'd6, 5'd0};
      for (int k = 0; k < 3; k++) begin
         set_instr(5'd1, 5'd2, lw_rd[k], 32'h100, 32'h0, 32'h8, 5'd0, 2'b01, 1'b1,
                   1'b1, 1'b1, 1'b0, 1'b1);
         advance();
         got = dut_out(); e = sb.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++; $display("FAIL lw_load[%0d]: got %h expected %h", k, got, e);
         end
         // consumer: rs for k=0, rt for k=1, r0 for k=2
         set_instr(k == 1 ? 5'd7 : lw_rd[k], k == 1 ? lw_rd[k] : 5'd8, 5'd9,
                   32'hA0 + k, 32'hB0, 32'h0, 5'd0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         #1;
         n_checks++;
         if (load_use_hazard !== hz_model() || load_use_hazard !== (k != 2)) begin
            n_fail++; $display("FAIL hazard_detect[%0d]: got %b expected %b", k, load_use_hazard, k != 2);
         end
         if (k == 1) begin
            flush = 1; #1;
            n_checks++;
            if (load_use_hazard !== 1'b0) begin
               n_fail++; $display("FAIL hazard_flush_mask: got %b expected 0", load_use_hazard);
            end
         end
         advance();
         got = dut_out(); e = sb.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++; $display("FAIL hazard_bubble[%0d]: got %h expected %h", k, got, e);
         end
         flush = 0; #1;
         n_checks++;
         if (load_use_hazard !== 1'b0) begin
            n_fail++; $display("FAIL hazard_drop[%0d]: got %b expected 0", k, load_use_hazard);
         end
         advance();
         got = dut_out(); e = sb.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++; $display("FAIL consumer_load[%0d]: got %h expected %h", k, got, e);
         end
      end
   endtask

   task automatic test_stall();
      set_instr(5'd10, 5'd11, 5'd12, 32'h5555, 32'h6666, 32'h7, 5'd3, 2'b11, 1'b0,
                1'b1, 1'b0, 1'b1, 1'b0);
      advance();
      void'(sb.pop_front());
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         set_instr(5'(i), 5'(i + 1), 5'(i + 20), $urandom, $urandom, $urandom, 5'(i), 2'(i),
                   1'(i), 1'b1, 1'b0, 1'b0, 1'b1);
         advance();
         got = dut_out(); e = sb.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, got, e);
         end
      end
      flush = 1;
      advance();
      got = dut_out(); e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
         n_fail++; $display("FAIL flush_over_stall: got %h expected %h", got, e);
      end
      flush = 0; stall = 0;
      set_instr(5'd1, 5'd2, 5'd3, 32'h9, 32'h8, 32'h0, 5'd1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      advance();
      void'(sb.pop_front());
      rst = 1; stall = 1; flush = 1;
      advance();
      got = dut_out(); e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
         n_fail++; $display("FAIL midop_reset: got %h expected %h", got, e);
      end
      rst = 0; stall = 0; flush = 0;
   endtask

   task automatic test_forward();
      set_instr(5'd2, 5'd3, 5'd4, 32'hAA, 32'hBB, 32'h0, 5'd0, 2'b01, 1'b0,
                1'b1, 1'b0, 1'b0, 1'b0);
      advance();
      got = dut_out(); e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
         n_fail++; $display("FAIL fwd_base_load: got %h expected %h", got, e);
      end
      exmem_regwrite = 1; exmem_rd = 5'd2; exmem_result = 32'h11;
      memwb_regwrite = 1; memwb_rd = 5'd2; memwb_result = 32'h22;
      #1;
      n_checks++;
      if (ex_src1 !== (FWD ? 32'h11 : 32'hAA)) begin
         n_fail++; $display("FAIL fwd_exmem_prio: got %h expected %h", ex_src1, FWD ? 32'h11 : 32'hAA);
      end
      exmem_regwrite = 0; #1;
      n_checks++;
      if (ex_src1 !== (FWD ? 32'h22 : 32'hAA)) begin
         n_fail++; $display("FAIL fwd_memwb: got %h expected %h", ex_src1, FWD ? 32'h22 : 32'hAA);
      end
      memwb_regwrite = 0; exmem_regwrite = 1; exmem_rd = 5'd3; exmem_result = 32'h33; #1;
      n_checks++;
      if (ex_src1 !== 32'hAA || ex_src2 !== (FWD ? 32'h33 : 32'hBB) ||
          ex_store_data !== (FWD ? 32'h33 : 32'hBB)) begin
         n_fail++; $display("FAIL fwd_rt: src1 %h src2 %h store %h expected aa %h %h",
                            ex_src1, ex_src2, ex_store_data, FWD ? 32'h33 : 32'hBB, FWD ? 32'h33 : 32'hBB);
      end
      exmem_regwrite = 0;
      set_instr(5'd0, 5'd0, 5'd4, 32'h55, 32'h66, 32'h0, 5'd0, 2'b01, 1'b0,
                1'b1, 1'b0, 1'b0, 1'b0);
      advance();
      void'(sb.pop_front());
      exmem_regwrite = 1; exmem_rd = 5'd0; exmem_result = 32'h99;
      memwb_regwrite = 1; memwb_rd = 5'd0; memwb_result = 32'h77;
      #1;
      n_checks++;
      if (ex_src1 !== 32'h55 || ex_store_data !== 32'h66) begin
         n_fail++; $display("FAIL fwd_r0: src1 %h store %h expected 55 66", ex_src1, ex_store_data);
      end
      exmem_regwrite = 0; memwb_regwrite = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1;
      set_idle();
      @(negedge clk);
      test_reset();
      test_basic();
      test_imm();
      test_load_use();
      test_stall();
      test_forward();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
